// File: rtl/morse_msg_scheduler.sv
// Morse message scheduler: buffers character codes in a small FIFO and
// hands letters one at a time to a Morse emitter, inserting inter-letter
// and word-space gaps between them.
`timescale 1ns/1ps
module morse_msg_scheduler #(
   parameter int DEPTH      = 8,
   parameter int LETTER_GAP = 299,
   parameter int WORD_GAP   = 699
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [4:0]                 in_char,
   output logic                       in_ready,
   input  logic                       abort,
   output logic [4:0]                 emit_sel,
   output logic                       emit_start,
   input  logic                       emit_done,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       err_char
);

   localparam int         AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int         CW    = $clog2(DEPTH + 1);
   localparam int         GMAX  = (LETTER_GAP > WORD_GAP) ? LETTER_GAP : WORD_GAP;
   localparam int         GW    = (GMAX > 0) ? $clog2(GMAX + 1) : 1;
   localparam logic [4:0] SPACE = 5'd31;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } state_t;

   state_t        state;
   logic [4:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [GW-1:0] gap_cnt;
   logic [4:0]    head;
   logic          legal;
   logic          accept;
   logic          wr_en;
   logic          rd_en;

   assign in_ready = (fifo_count < CW'(DEPTH));
   assign busy     = (state != IDLE) || (fifo_count != '0);

   // Handshake decode: illegal codes are accepted but never stored; abort discards a same-cycle push.
   always_comb begin
      legal  = (in_char < 5'd26) || (in_char == SPACE);
      accept = in_valid && in_ready && !abort;
      wr_en  = accept && legal;
      rd_en  = (state == IDLE) && (fifo_count != '0) && !abort;
      head   = mem[rd_ptr];
   end

   // Character storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= in_char;
      end
   end

   // FIFO pointers, occupancy and the illegal-code error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         err_char   <= 1'b0;
      end else if (abort) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         err_char   <= 1'b0;
      end else begin
         err_char <= accept && !legal;
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Scheduler FSM: pop, launch the emitter for one cycle, wait for it, then time the gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         gap_cnt    <= '0;
         emit_sel   <= '0;
         emit_start <= 1'b0;
      end else if (abort) begin
         state      <= IDLE;
         gap_cnt    <= '0;
         emit_start <= 1'b0;
      end else begin
         emit_start <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_en) begin
                  if (head == SPACE) begin
                     gap_cnt <= GW'(WORD_GAP);
                     state   <= GAP;
                  end else begin
                     emit_sel   <= head;
                     emit_start <= 1'b1;
                     state      <= LAUNCH;
                  end
               end
            end
            LAUNCH: begin
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (emit_done) begin
                  gap_cnt <= GW'(LETTER_GAP);
                  state   <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_msg_scheduler.sv
// Self-checking bench for morse_msg_scheduler (DEPTH=4, LETTER_GAP=3, WORD_GAP=7).
// Expected waveforms come from a timeline model: each queued letter starts at
// its pop edge, each finished letter or space is followed by its gap length
// plus one idle cycle before the next pop.
`timescale 1ns/1ps
module tb_morse_msg_scheduler;
   localparam int DEPTH = 4;
   localparam int LG    = 3;
   localparam int WG    = 7;
   localparam int RMAX  = 128;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid;
   logic [4:0] in_char;
   logic       in_ready;
   logic       abort;
   logic [4:0] emit_sel;
   logic       emit_start;
   logic       emit_done;
   logic       busy;
   logic [2:0] fifo_count;
   logic       err_char;

   int ncmp  = 0;
   int nfail = 0;

   logic [4:0] pcodes [8];
   int         dly [8];
   int         npush;

   logic [4:0] c6 [6];
   int         pushed, started, dtimer;
   logic       acc;

   morse_msg_scheduler #(.DEPTH(DEPTH), .LETTER_GAP(LG), .WORD_GAP(WG)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_char   (in_char),
      .in_ready  (in_ready),
      .abort     (abort),
      .emit_sel  (emit_sel),
      .emit_start(emit_start),
      .emit_done (emit_done),
      .busy      (busy),
      .fifo_count(fifo_count),
      .err_char  (err_char)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ncmp++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   // Drive inputs for the next rising edge, then sample on the falling edge.
   task automatic step(input logic v, input logic [4:0] c, input logic ab, input logic dn);
      in_valid  = v;
      in_char   = c;
      abort     = ab;
      emit_done = dn;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, " emit_sel"},   32'(emit_sel),   32'd0);
      chk({tag, " emit_start"}, 32'(emit_start), 32'd0);
      chk({tag, " err_char"},   32'(err_char),   32'd0);
      chk({tag, " busy"},       32'(busy),       32'd0);
      chk({tag, " in_ready"},   32'(in_ready),   32'd1);
      chk({tag, " fifo_count"}, 32'(fifo_count), 32'd0);
   endtask

   // Pushes pcodes[0..npush-1] on consecutive edges from an idle, empty block and
   // compares every cycle against the timeline model. Letter j is finished dly[j]
   // edges after its start edge; stray emit_done pulses fill all other cycles.
   task automatic run_round(input string tag);
      logic       e_start [RMAX];
      logic       e_err   [RMAX];
      logic       e_busy  [RMAX];
      logic       drv     [RMAX];
      logic [4:0] e_sel   [RMAX];
      int         e_cnt   [RMAX];
      int         lpush[$];
      int         lcode[$];
      int         popr[$];
      int         p, pn, d, r_end, c;
      for (int r = 0; r < RMAX; r++) begin
         e_start[r] = 1'b0;
         e_err[r]   = 1'b0;
         e_busy[r]  = 1'b0;
         e_sel[r]   = '0;
         e_cnt[r]   = 0;
         drv[r]     = ($urandom_range(0, 3) == 0);
      end
      for (int i = 0; i < npush; i++) begin
         if (pcodes[i] >= 5'd26 && pcodes[i] <= 5'd30) e_err[i] = 1'b1;
         else begin
            lpush.push_back(i);
            lcode.push_back(int'(pcodes[i]));
         end
      end
      p = 0;
      foreach (lpush[j]) begin
         if (p < lpush[j] + 1) p = lpush[j] + 1;
         popr.push_back(p);
         if (lcode[j] == 31) pn = p + WG + 2;
         else begin
            d = dly[j];
            e_start[p] = 1'b1;
            e_sel[p]   = 5'(lcode[j]);
            for (int r = p + 2; r < p + d; r++) drv[r] = 1'b0;
            drv[p + d] = 1'b1;
            pn = p + d + LG + 2;
         end
         for (int r = p; r <= pn - 2; r++) e_busy[r] = 1'b1;
         p = pn;
      end
      r_end = ((p > npush) ? p : npush) + 3;
      for (int r = 0; r < r_end; r++) begin
         c = 0;
         foreach (lpush[j]) if (lpush[j] <= r) c++;
         foreach (popr[j]) if (popr[j] <= r) c--;
         e_cnt[r] = c;
         if (c != 0) e_busy[r] = 1'b1;
      end
      for (int r = 0; r < r_end; r++) begin
         step(r < npush, (r < npush) ? pcodes[r] : 5'd0, 1'b0, drv[r]);
         chk({tag, " emit_start"}, 32'(emit_start), 32'(e_start[r]));
         if (e_start[r]) chk({tag, " emit_sel"}, 32'(emit_sel), 32'(e_sel[r]));
         chk({tag, " err_char"},   32'(err_char),   32'(e_err[r]));
         chk({tag, " busy"},       32'(busy),       32'(e_busy[r]));
         chk({tag, " fifo_count"}, 32'(fifo_count), 32'(e_cnt[r]));
         chk({tag, " in_ready"},   32'(in_ready),   32'(e_cnt[r] < DEPTH));
      end
      in_valid  = 1'b0;
      emit_done = 1'b0;
   endtask

   initial begin
      in_valid  = 1'b0;
      in_char   = '0;
      abort     = 1'b0;
      emit_done = 1'b0;

      // Reset state, observed before the first clock edge.
      #1 rst = 1'b1;
      #2 chk_reset_values("reset");
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 5'd0, 1'b0, 1'b0);

      // Single 'E', finished at edge 5; busy drops at edge 9.
      pcodes[0] = 5'd4; dly[0] = 4; npush = 1;
      run_round("letter_e");

      // 'A', space, 'B': letter gap then word gap before B starts.
      pcodes[0] = 5'd0; pcodes[1] = 5'd31; pcodes[2] = 5'd1;
      dly[0] = 3; dly[1] = 2; dly[2] = 3; npush = 3;
      run_round("a_sp_b");

      // Illegal code 27: accepted, error pulse, nothing queued.
      pcodes[0] = 5'd27; npush = 1;
      run_round("illegal");

      // Six letters back to back with the first completion withheld.
      foreach (c6[i]) c6[i] = 5'($urandom_range(0, 25));
      pushed = 0; started = 0; dtimer = -1;
      for (int t = 0; t < 300; t++) begin
         if (started == 6 && pushed == 6 && busy === 1'b0) break;
         acc = (pushed < 6) && (in_ready === 1'b1);
         step(pushed < 6, c6[(pushed < 6) ? pushed : 0], 1'b0, dtimer == 0);
         if (acc) pushed++;
         if (dtimer >= 0) dtimer--;
         if (t == 4) begin
            chk("full fifo_count", 32'(fifo_count), 32'd4);
            chk("full in_ready",   32'(in_ready),   32'd0);
         end
         if (emit_start === 1'b1) begin
            if (started < 6) chk("order emit_sel", 32'(emit_sel), 32'(c6[started]));
            started++;
            dtimer = (started == 1) ? 20 : 1;
         end
      end
      in_valid = 1'b0;
      chk("order started", 32'(started), 32'd6);
      chk("order pushed",  32'(pushed),  32'd6);
      chk("order busy",    32'(busy),    32'd0);

      // Abort while waiting on the emitter with three letters queued.
      step(1'b1, 5'd7,  1'b0, 1'b0);
      step(1'b1, 5'd8,  1'b0, 1'b0);
      step(1'b1, 5'd9,  1'b0, 1'b0);
      step(1'b1, 5'd10, 1'b0, 1'b0);
      chk("abort pre fifo_count", 32'(fifo_count), 32'd3);
      step(1'b0, 5'd0,  1'b0, 1'b0);
      step(1'b1, 5'd11, 1'b1, 1'b0);
      chk("abort fifo_count", 32'(fifo_count), 32'd0);
      chk("abort busy",       32'(busy),       32'd0);
      chk("abort emit_start", 32'(emit_start), 32'd0);
      step(1'b0, 5'd0, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 5'd0, 1'b0, 1'b0);
         chk("post abort emit_start", 32'(emit_start), 32'd0);
         chk("post abort busy",       32'(busy),       32'd0);
      end

      // Asynchronous reset while emit_start is high; a late emit_done is ignored.
      step(1'b1, 5'd4, 1'b0, 1'b0);
      step(1'b0, 5'd0, 1'b0, 1'b0);
      chk("pre rst emit_start", 32'(emit_start), 32'd1);
      #2 rst = 1'b1;
      #1 chk_reset_values("rst launch");
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 5'd0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 5'd0, 1'b0, 1'b0);
         chk("post rst emit_start", 32'(emit_start), 32'd0);
         chk("post rst busy",       32'(busy),       32'd0);
      end

      // Asynchronous reset during the letter gap with another letter queued.
      step(1'b1, 5'd4,  1'b0, 1'b0);
      step(1'b0, 5'd0,  1'b0, 1'b0);
      step(1'b0, 5'd0,  1'b0, 1'b0);
      step(1'b0, 5'd0,  1'b0, 1'b1);
      step(1'b1, 5'd19, 1'b0, 1'b0);
      in_valid = 1'b0;
      chk("gap busy",       32'(busy),       32'd1);
      chk("gap fifo_count", 32'(fifo_count), 32'd1);
      #2 rst = 1'b1;
      #1 chk_reset_values("rst gap");
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 5'd0, 1'b0, 1'b0);

      // Normal operation after reset, then randomized messages.
      pcodes[0] = 5'd19; dly[0] = 2; npush = 1;
      run_round("resume");
      for (int k = 0; k < 30; k++) begin
         int nl;
         npush = 0;
         nl = $urandom_range(1, 4);
         for (int j = 0; j < nl; j++) begin
            if ($urandom_range(0, 3) == 0) begin
               pcodes[npush] = 5'(26 + $urandom_range(0, 4));
               npush++;
            end
            pcodes[npush] = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 25));
            npush++;
            dly[j] = $urandom_range(2, 6);
         end
         run_round("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/morse_msg_scheduler.md
MORSE_MSG_SCHEDULER -- requirements
Module: morse_msg_scheduler

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  DEPTH  8  character FIFO entries, power of two, 2 or more
  LETTER_GAP  299  inter-letter gap, in cycles minus one
  WORD_GAP  699  word-space gap, in cycles minus one
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all logic on rising edge
  rst  in  1  asynchronous, active-high reset
  in_valid  in  1  character offered
  in_char  in  5  0-25 = A-Z, 31 = word space, 26-30 = illegal
  in_ready  out  1  FIFO can accept
  abort  in  1  synchronous flush/stop
  emit_sel  out  5  letter code to Morse emitter, registered
  emit_start  out  1  one-cycle start pulse to emitter
  emit_done  in  1  emitter finished current letter (pulse)
  busy  out  1  message in progress
  fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy
  err_char  out  1  one-cycle pulse, illegal code received

Function
REQ-003 FIFO: in_ready = (fifo_count < DEPTH); transfer on in_valid && in_ready at a clock edge; read/write pointers wrap modulo DEPTH.
REQ-004 Illegal codes 26-30 SHALL complete the handshake, SHALL NOT be written, and SHALL pulse err_char in the cycle after the accepting edge.
REQ-005 FSM states: IDLE, LAUNCH, WAIT_DONE, GAP; 2-bit encoding.
REQ-006 IDLE with fifo_count > 0: pop head at the edge; letter -> emit_sel <= code and enter LAUNCH; space (31) -> gap counter <= WORD_GAP and enter GAP.
REQ-007 LAUNCH lasts exactly one cycle with emit_start = 1, then enters WAIT_DONE; emit_start SHALL be 0 in every other state.
REQ-008 WAIT_DONE: hold emit_sel; on emit_done = 1, gap counter <= LETTER_GAP and enter GAP; emit_done SHALL be ignored outside WAIT_DONE.
REQ-009 GAP: counter decrements by 1 per cycle; at counter == 0, enter IDLE. GAP occupancy = loaded value + 1 cycles.
REQ-010 A space following a letter SHALL produce LETTER_GAP+1 cycles, then WORD_GAP+1 cycles; consecutive spaces accumulate likewise.
REQ-011 Latency: a character pushed into an empty FIFO while in IDLE at edge E0 SHALL be popped at E1; emit_start is high between E1 and E2.
REQ-012 Simultaneous push and pop in the same edge SHALL leave fifo_count unchanged; push when full is impossible (in_ready = 0).
REQ-013 busy = (state != IDLE) || (fifo_count != 0).
REQ-014 abort = 1 at an edge SHALL empty the FIFO, zero the counter, and enter IDLE; a push in the same cycle SHALL be discarded; no emit_start is issued.
REQ-015 Gap counter width = $clog2(max(LETTER_GAP, WORD_GAP) + 1); no overflow is possible.

Reset
REQ-016 rst = 1 SHALL asynchronously force: state IDLE, FIFO pointers 0, fifo_count 0, counter 0, emit_sel 0, emit_start 0, err_char 0, busy 0, in_ready 1.
REQ-017 Reset asserted mid-letter SHALL drop emit_start immediately; any later emit_done SHALL be ignored.

Verification (bench parameters: DEPTH = 4, LETTER_GAP = 3, WORD_GAP = 7)
REQ-018 Push 'E' (4) into idle block at edge 0 -> pop at edge 1; emit_sel = 4 and emit_start high for 1 cycle; emit_done at edge 5 -> GAP for 4 cycles -> IDLE; busy falls to 0.
REQ-019 Push 5 characters back to back with emit_done withheld -> in_ready low once fifo_count = 4 (after first pop: count reaches 4 with 5th accepted only after pop); no data loss; order preserved on emit_sel.
REQ-020 Push 'A', 31, 'B' -> after A done: 4-cycle letter gap + 8-cycle word gap before B's emit_start.
REQ-021 Push code 27 -> accepted, err_char pulses once, fifo_count stays 0, no emit_start.
REQ-022 Assert abort during WAIT_DONE with 3 queued -> next cycle: IDLE, fifo_count 0, busy 0; emit_done pulse afterward has no effect.
REQ-023 Assert rst asynchronously during GAP -> all outputs reach reset values before the next clock edge; normal operation resumes after release.
